// File: rtl/alt_eyemon_csr_pkg.sv
// Shared register offsets, CTRL bit positions and FSM encoding for the eye-monitor CSR slave.
// No logic; latency and backpressure are properties of the modules that import it.
// Optional timeout watchdog in the importers is enabled by ALT_EYEMON_CSR_TIMEOUT_EN.
package alt_eyemon_csr_pkg;

   localparam int REG_CTRL   = 0;
   localparam int REG_CHADDR = 1;
   localparam int REG_WDADDR = 2;
   localparam int REG_DATA   = 3;

   localparam int CTRL_START_BIT    = 0;
   localparam int CTRL_RWN_BIT      = 1;
   localparam int CTRL_REMAP_BIT    = 2;
   localparam int CTRL_BUSY_BIT     = 8;
   localparam int CTRL_ADDR_ERR_BIT = 9;
   localparam int CTRL_TMO_ERR_BIT  = 10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/alt_eyemon_csr_regfile.sv
// CSR storage, W1C error flags and registered readback mux (read latency 1).
// No waitrequest: reads always accepted; operand writes are dropped while busy.
// timeout_err storage exists only when ALT_EYEMON_CSR_TIMEOUT_EN is defined.
module alt_eyemon_csr_regfile
   import alt_eyemon_csr_pkg::*;
#(
   parameter int SADDR_WIDTH       = 3,
   parameter int IREG_CHADDR_WIDTH = 16,
   parameter int IREG_WDADDR_WIDTH = 16,
   parameter int IREG_DATA_WIDTH   = 16
) (
   input  logic                         i_avmm_clk,
   input  logic                         i_resetn,
   input  logic [SADDR_WIDTH-1:0]       saddress,
   input  logic                         sread,
   input  logic                         swrite,
   input  logic [IREG_DATA_WIDTH-1:0]   swritedata,
   input  logic                         busy,
   input  logic                         set_addr_err,
   input  logic                         set_timeout_err,
   input  logic                         capture_vld,
   input  logic [IREG_DATA_WIDTH-1:0]   capture_dat,
   output logic [IREG_DATA_WIDTH-1:0]   readdata,
   output logic                         readdatavalid,
   output logic                         start_req,
   output logic [IREG_CHADDR_WIDTH-1:0] chaddr,
   output logic [IREG_WDADDR_WIDTH-1:0] wdaddr,
   output logic [IREG_DATA_WIDTH-1:0]   wdata,
   output logic                         rwn,
   output logic                         remap
);

   logic                       wr_ctrl;
   logic                       wr_chaddr;
   logic                       wr_wdaddr;
   logic                       wr_data;
   logic                       addr_err;
   logic                       timeout_err;
   logic [IREG_DATA_WIDTH-1:0] rdata_cap;
   logic [IREG_DATA_WIDTH-1:0] ctrl_rd;
   logic [IREG_DATA_WIDTH-1:0] rd_mux;

   assign wr_ctrl   = swrite && (saddress == SADDR_WIDTH'(REG_CTRL));
   assign wr_chaddr = swrite && (saddress == SADDR_WIDTH'(REG_CHADDR));
   assign wr_wdaddr = swrite && (saddress == SADDR_WIDTH'(REG_WDADDR));
   assign wr_data   = swrite && (saddress == SADDR_WIDTH'(REG_DATA));

   // start is only meaningful from IDLE; the FSM validates addresses
   assign start_req = wr_ctrl && swritedata[CTRL_START_BIT] && !busy;

   always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         chaddr    <= '0;
         wdaddr    <= '0;
         wdata     <= '0;
         rwn       <= 1'b0;
         remap     <= 1'b0;
         addr_err  <= 1'b0;
         rdata_cap <= '0;
      end else begin
         if (wr_chaddr && !busy) chaddr <= IREG_CHADDR_WIDTH'(swritedata);
         if (wr_wdaddr && !busy) wdaddr <= IREG_WDADDR_WIDTH'(swritedata);
         if (wr_data && !busy)   wdata  <= swritedata;
         if (wr_ctrl && !busy) begin
            rwn   <= swritedata[CTRL_RWN_BIT];
            remap <= swritedata[CTRL_REMAP_BIT];
         end
         // a new error outranks a simultaneous clear
         if (set_addr_err)
            addr_err <= 1'b1;
         else if (wr_ctrl && swritedata[CTRL_ADDR_ERR_BIT])
            addr_err <= 1'b0;
         if (capture_vld) rdata_cap <= capture_dat;
      end
   end

`ifdef ALT_EYEMON_CSR_TIMEOUT_EN
   always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
      if (!i_resetn)
         timeout_err <= 1'b0;
      else if (set_timeout_err)
         timeout_err <= 1'b1;
      else if (wr_ctrl && swritedata[CTRL_TMO_ERR_BIT])
         timeout_err <= 1'b0;
   end
`else
   logic unused_set_timeout_err;
   assign unused_set_timeout_err = set_timeout_err;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      ctrl_rd                    = '0;
      ctrl_rd[CTRL_RWN_BIT]      = rwn;
      ctrl_rd[CTRL_REMAP_BIT]    = remap;
      ctrl_rd[CTRL_BUSY_BIT]     = busy;
      ctrl_rd[CTRL_ADDR_ERR_BIT] = addr_err;
      ctrl_rd[CTRL_TMO_ERR_BIT]  = timeout_err;
   end

   always_comb begin
      rd_mux = '0;
      case (saddress)
         SADDR_WIDTH'(REG_CTRL):   rd_mux = ctrl_rd;
         SADDR_WIDTH'(REG_CHADDR): rd_mux = IREG_DATA_WIDTH'(chaddr);
         SADDR_WIDTH'(REG_WDADDR): rd_mux = IREG_DATA_WIDTH'(wdaddr);
         SADDR_WIDTH'(REG_DATA):   rd_mux = rdata_cap;
         default:                  rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         readdata      <= '0;
         readdatavalid <= 1'b0;
      end else begin
         readdatavalid <= sread;
         if (sread) readdata <= rd_mux;
      end
   end

endmodule

// File: rtl/alt_eyemon_avmm_csr_slave.sv
// Avalon-MM CSR slave driving the eye-monitor ir interface; start-to-trigger 1 cycle, read latency 1.
// No waitrequest; busy gates operand writes. Watchdog abort enabled by ALT_EYEMON_CSR_TIMEOUT_EN.
module alt_eyemon_avmm_csr_slave
   import alt_eyemon_csr_pkg::*;
#(
   parameter int NUM_CHANNELS      = 4,
   parameter int NUM_WORDS         = 2,
   parameter int SADDR_WIDTH       = 3,
   parameter int IREG_CHADDR_WIDTH = 16,
   parameter int IREG_WDADDR_WIDTH = 16,
   parameter int IREG_DATA_WIDTH   = 16,
   parameter int TIMEOUT_CYCLES    = 1024
) (
   input  logic                         i_avmm_clk,
   input  logic                         i_resetn,
   input  logic [SADDR_WIDTH-1:0]       i_avmm_saddress,
   input  logic                         i_avmm_sread,
   input  logic                         i_avmm_swrite,
   input  logic [IREG_DATA_WIDTH-1:0]   i_avmm_swritedata,
   output logic [IREG_DATA_WIDTH-1:0]   o_avmm_sreaddata,
   output logic                         o_avmm_sreaddatavalid,
   output logic                         o_ir_trigger,
   output logic [IREG_CHADDR_WIDTH-1:0] o_ir_chaddress,
   output logic [IREG_WDADDR_WIDTH-1:0] o_ir_wdaddress,
   output logic [IREG_DATA_WIDTH-1:0]   o_ir_writedata,
   output logic                         o_ir_rwn,
   input  logic                         i_ir_done,
   input  logic [IREG_DATA_WIDTH-1:0]   i_ir_readdata,
   output logic                         o_remap,
   output logic                         o_busy
);

   localparam logic [IREG_CHADDR_WIDTH-1:0] CH_LIMIT = IREG_CHADDR_WIDTH'(NUM_CHANNELS);
   localparam logic [IREG_WDADDR_WIDTH-1:0] WD_LIMIT = IREG_WDADDR_WIDTH'(NUM_WORDS);

   logic [1:0] state;
   logic       start_req;
   logic       addr_ok;
   logic       set_addr_err;
   logic       set_timeout_err;
   logic       capture_vld;
   logic       tmo_hit;

   assign o_busy       = (state != ST_IDLE);
   assign o_ir_trigger = (state == ST_ISSUE);
   assign addr_ok      = (o_ir_chaddress < CH_LIMIT) && (o_ir_wdaddress < WD_LIMIT);
   assign set_addr_err = start_req && !addr_ok;
   assign capture_vld  = (state == ST_WAIT) && i_ir_done && o_ir_rwn;

`ifdef ALT_EYEMON_CSR_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] wait_cnt;

   // WAIT lasts TIMEOUT_CYCLES cycles at most; done in the final cycle still wins
   assign tmo_hit = (state == ST_WAIT) && !i_ir_done && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
      if (!i_resetn)
         wait_cnt <= '0;
      else if (state != ST_WAIT)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   assign set_timeout_err = tmo_hit;

   always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start_req && addr_ok) state <= ST_ISSUE;
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT:  if (i_ir_done || tmo_hit) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   alt_eyemon_csr_regfile #(
      .SADDR_WIDTH       (SADDR_WIDTH),
      .IREG_CHADDR_WIDTH (IREG_CHADDR_WIDTH),
      .IREG_WDADDR_WIDTH (IREG_WDADDR_WIDTH),
      .IREG_DATA_WIDTH   (IREG_DATA_WIDTH)
   ) u_regfile (
      .i_avmm_clk      (i_avmm_clk),
      .i_resetn        (i_resetn),
      .saddress        (i_avmm_saddress),
      .sread           (i_avmm_sread),
      .swrite          (i_avmm_swrite),
      .swritedata      (i_avmm_swritedata),
      .busy            (o_busy),
      .set_addr_err    (set_addr_err),
      .set_timeout_err (set_timeout_err),
      .capture_vld     (capture_vld),
      .capture_dat     (i_ir_readdata),
      .readdata        (o_avmm_sreaddata),
      .readdatavalid   (o_avmm_sreaddatavalid),
      .start_req       (start_req),
      .chaddr          (o_ir_chaddress),
      .wdaddr          (o_ir_wdaddress),
      .wdata           (o_ir_writedata),
      .rwn             (o_ir_rwn),
      .remap           (o_remap)
   );

endmodule
